leds_pattern_ctrl: RTL and testbench

//  Registered, parametrised successor to the combinational LED mapper. Drives N_LEDS outputs from a latched pattern.

---
 rtl/leds_pattern_ctrl_pkg.sv | 17 +
 rtl/leds_pattern_ctrl_tick_gen.sv | 32 +++
 rtl/leds_pattern_ctrl.sv | 104 ++++++++++
 tb/tb_leds_pattern_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leds_pattern_ctrl_pkg.sv
// rtl/leds_pattern_ctrl_pkg.sv - mode codes and shared types for the LED pattern controller
package leds_pattern_ctrl_pkg;

    // Mode codes shared by every block that decodes mode/mode_q
    typedef enum logic [1:0] {
        LED_MODE_DIRECT = 2'd0,
        LED_MODE_BLINK  = 2'd1,
        LED_MODE_PWM    = 2'd2,
        LED_MODE_SCROLL = 2'd3
    } led_mode_e;

    // Counter width for a modulo-n counter, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leds_pattern_ctrl_tick_gen.sv
// rtl/leds_pattern_ctrl_tick_gen.sv - prescaler producing a one-cycle tick every PRESCALE clocks
module led_tick_gen
    import leds_pattern_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Count 0..PRESCALE-1; tick is registered so it lands the cycle after the wrap value; clr restarts the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/leds_pattern_ctrl.sv
// rtl/leds_pattern_ctrl.sv - registered LED driver with direct, blink, PWM and scroll modes
module leds_pattern_ctrl
    import leds_pattern_ctrl_pkg::*;
#(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LEDS-1:0]   in,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                scroll_dir,
    input  logic                load,
    output logic [N_LEDS-1:0]   out,
    output logic                tick
);

    logic [N_LEDS-1:0]   pat;
    led_mode_e           mode_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_ph;
    logic                pwm_on;
    logic [N_LEDS-1:0]   out_next;
    logic [N_LEDS-1:0]   pat_rot;

    // Load restarts the prescaler so a new setting always begins on a full period
    led_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (load),
        .tick (tick)
    );

    // One-position wrapping rotation; left moves bit i to i+1
    always_comb begin
        pat_rot = pat;
        if (scroll_dir) begin
            pat_rot = {pat[0], pat[N_LEDS-1:1]};
        end else begin
            pat_rot = {pat[N_LEDS-2:0], pat[N_LEDS-1]};
        end
    end

    // Pattern/mode/duty latching, blink phase and scroll; load takes priority over a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat      <= '0;
            mode_q   <= LED_MODE_DIRECT;
            duty_q   <= '0;
            blink_ph <= 1'b1;
        end else if (load) begin
            pat      <= in;
            mode_q   <= led_mode_e'(mode);
            duty_q   <= duty;
            blink_ph <= 1'b1;
        end else if (tick) begin
            blink_ph <= ~blink_ph;
            if (mode_q == LED_MODE_SCROLL) begin
                pat <= pat_rot;
            end
        end
    end

    // Free-running PWM counter, deliberately untouched by load so dimming phase is continuous
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // All-ones duty forces always-on, since the counter can never exceed its own maximum
    always_comb begin
        pwm_on = (pwm_cnt < duty_q) | (&duty_q);
    end

    // Output selection from the current registered state
    always_comb begin
        out_next = pat;
        case (mode_q)
            LED_MODE_DIRECT: out_next = pat;
            LED_MODE_BLINK:  out_next = blink_ph ? pat : '0;
            LED_MODE_PWM:    out_next = pwm_on ? pat : '0;
            LED_MODE_SCROLL: out_next = pat;
            default:         out_next = pat;
        endcase
    end

    // Registered LED drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_leds_pattern_ctrl.sv
// tb/tb_leds_pattern_ctrl.sv - self-checking bench for leds_pattern_ctrl
module tb_leds_pattern_ctrl;

    localparam int P = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [1:0] mode;
    logic [3:0] duty;
    logic       scroll_dir;
    logic       load;
    logic [7:0] out;
    logic       tick;

    int checks;
    int errors;

    // Reference model state: pattern, settings, blink phase, edges since last restart, PWM position
    int m_pat, m_mode, m_duty, m_ph, m_since, m_pwm, m_out, m_tick;

    leds_pattern_ctrl #(
        .N_LEDS(8),
        .PWM_BITS(4),
        .PRESCALE(P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .mode      (mode),
        .duty      (duty),
        .scroll_dir(scroll_dir),
        .load      (load),
        .out       (out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pat = 0; m_mode = 0; m_duty = 0; m_ph = 1;
        m_since = 0; m_pwm = 0; m_out = 0; m_tick = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the rising edge, return 1 time unit after it
    task automatic step(input bit ld, input logic [7:0] d, input logic [1:0] md,
                        input logic [3:0] dt, input bit dir);
        int lit;
        @(negedge clk);
        load = ld; din = d; mode = md; duty = dt; scroll_dir = dir;
        @(posedge clk);
        case (m_mode)
            1: m_out = m_ph ? m_pat : 0;
            2: m_out = ((m_pwm < m_duty) || (m_duty == 15)) ? m_pat : 0;
            default: m_out = m_pat;
        endcase
        if (ld) begin
            m_pat = d; m_mode = md; m_duty = dt; m_ph = 1; m_since = 0;
        end else begin
            if (m_tick) begin
                m_ph = 1 - m_ph;
                if (m_mode == 3) begin
                    lit = dir ? ((m_pat >> 1) | ((m_pat & 1) << 7)) : ((m_pat << 1) | (m_pat >> 7));
                    m_pat = lit & 8'hFF;
                end
            end
            m_since = m_since + 1;
        end
        m_tick = (m_since > 0 && (m_since % P) == 0) ? 1 : 0;
        m_pwm = (m_pwm + 1) % 16;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; din = '0; mode = '0; duty = '0; scroll_dir = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", out); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        int ticks;
        step(1, 8'hA5, 2'd0, 4'd0, 0);
        step(0, 8'h3C, 2'd1, 4'd7, 0);
        checks++;
        if (out !== 8'hA5) begin errors++; $display("FAIL direct_out got %h want a5", out); end
        ticks = 0;
        for (int i = 0; i < 11; i++) begin
            if (tick === 1'b1) ticks++;
            checks++;
            if (out !== m_out[7:0] || tick !== m_tick[0]) begin
                errors++; $display("FAIL direct_cycle%0d got %h/%b want %h/%0d", i, out, tick, m_out[7:0], m_tick);
            end
            step(0, 8'h00, 2'd2, 4'd0, 0);
        end
        if (tick === 1'b1) ticks++;
        checks++;
        if (ticks !== 3) begin errors++; $display("FAIL direct_tick_count got %0d want 3", ticks); end
    endtask

    task automatic test_blink();
        step(1, 8'h0F, 2'd1, 4'd0, 0);
        for (int i = 1; i <= 13; i++) begin
            step(0, 8'hFF, 2'd0, 4'd0, 0);
            checks++;
            if (out !== m_out[7:0]) begin errors++; $display("FAIL blink_cycle%0d got %h want %h", i, out, m_out[7:0]); end
            if (i == 1 || i == 6 || i == 10) begin
                checks++;
                if (out !== ((i == 6) ? 8'h00 : 8'h0F)) begin
                    errors++; $display("FAIL blink_phase%0d got %h want %h", i, out, (i == 6) ? 8'h00 : 8'h0F);
                end
            end
        end
    endtask

    task automatic test_pwm();
        int on_cnt;
        logic [3:0] dlist [3];
        int want [3];
        dlist[0] = 4'd4;  want[0] = 8;
        dlist[1] = 4'd0;  want[1] = 0;
        dlist[2] = 4'd15; want[2] = 32;
        for (int k = 0; k < 3; k++) begin
            step(1, 8'hFF, 2'd2, dlist[k], 0);
            step(0, 8'h00, 2'd0, 4'd0, 0);
            on_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                step(0, 8'h00, 2'd0, 4'd0, 0);
                if (out === 8'hFF) on_cnt++;
                checks++;
                if (out !== m_out[7:0]) begin errors++; $display("FAIL pwm_d%0d_cycle%0d got %h want %h", dlist[k], i, out, m_out[7:0]); end
            end
            checks++;
            if (on_cnt !== want[k]) begin errors++; $display("FAIL pwm_d%0d_on_count got %0d want %0d", dlist[k], on_cnt, want[k]); end
        end
    endtask

    task automatic test_scroll();
        logic [7:0] prev, expv;
        int changes;
        step(1, 8'h01, 2'd3, 4'd0, 0);
        step(0, 8'h00, 2'd0, 4'd0, 0);
        checks++;
        if (out !== 8'h01) begin errors++; $display("FAIL scroll_start got %h want 01", out); end
        prev = out; expv = 8'h01; changes = 0;
        for (int i = 0; i < 40 && changes < 8; i++) begin
            step(0, 8'h00, 2'd0, 4'd0, 0);
            checks++;
            if (out !== m_out[7:0]) begin errors++; $display("FAIL scroll_cycle%0d got %h want %h", i, out, m_out[7:0]); end
            if (out !== prev) begin
                expv = {expv[6:0], expv[7]};
                changes++;
                checks++;
                if (out !== expv) begin errors++; $display("FAIL scroll_left%0d got %h want %h", changes, out, expv); end
                prev = out;
            end
        end
        checks++;
        if (changes !== 8 || out !== 8'h01) begin errors++; $display("FAIL scroll_wrap got %h after %0d steps want 01 after 8", out, changes); end
        step(1, 8'h01, 2'd3, 4'd0, 1);
        changes = 0;
        for (int i = 0; i < 10 && changes == 0; i++) begin
            step(0, 8'h00, 2'd0, 4'd0, 1);
            if (out !== 8'h01) changes = 1;
        end
        checks++;
        if (out !== 8'h80) begin errors++; $display("FAIL scroll_right got %h want 80", out); end
    endtask

    task automatic test_load_on_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            step(0, 8'h00, 2'd0, 4'd0, 0);
            n++;
        end
        checks++;
        if (tick !== 1'b1) begin errors++; $display("FAIL lot_wait_tick got %b want 1 within 10 cycles", tick); end
        step(1, 8'h3C, 2'd3, 4'd0, 0);
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL lot_tick_cleared got %b want 0", tick); end
        n = 1;
        step(0, 8'h00, 2'd0, 4'd0, 0);
        checks++;
        if (out !== 8'h3C) begin errors++; $display("FAIL lot_pattern got %h want 3c", out); end
        while (tick !== 1'b1 && n < 10) begin
            step(0, 8'h00, 2'd0, 4'd0, 0);
            n++;
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL lot_next_tick got %0d cycles want 4", n); end
        checks++;
        if (out !== 8'h3C) begin errors++; $display("FAIL lot_hold got %h want 3c", out); end
    endtask

    task automatic test_reset_mid();
        int n;
        step(1, 8'hC3, 2'd1, 4'd0, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 2'd0, 4'd0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out !== 8'h00 || tick !== 1'b0) begin errors++; $display("FAIL midreset_async got %h/%b want 00/0", out, tick); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 8'hFF, 2'd0, 4'd0, 0);
            if (tick === 1'b1 && n == 0) n = i + 1;
            checks++;
            if (out !== 8'h00 || out !== m_out[7:0]) begin errors++; $display("FAIL midreset_hold%0d got %h want 00", i, out); end
        end
        checks++;
        if (n !== P) begin errors++; $display("FAIL midreset_first_tick got cycle %0d want %0d", n, P); end
    endtask

    task automatic test_random();
        bit ld;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 5) == 0);
            step(ld, 8'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
            checks++;
            if (out !== m_out[7:0] || tick !== m_tick[0]) begin
                errors++; $display("FAIL random_cycle%0d got %h/%b want %h/%0d", i, out, tick, m_out[7:0], m_tick);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_direct();
        test_blink();
        test_pwm();
        test_scroll();
        test_load_on_tick();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
